// File: rtl/img_pkg.sv
// Shared image geometry and stream-FSM encoding for the filter/readback blocks.
// Address layout is {row, col}, so the raster index equals the BRAM address.
package img_pkg;

    localparam int IMG_ROWS  = 128;
    localparam int IMG_COLS  = 128;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 14;
    localparam int FRAME_PIX = IMG_ROWS * IMG_COLS;
    localparam int CNT_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry synchronous FIFO; head is combinational from storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push when full.
module pix_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_q == 2'd2));
    no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && count_q == 2'd0));

endmodule

// File: rtl/result_stream_reader.sv
// Streams the output BRAM frame in raster order as a valid/ready pixel stream.
// Latency: start at edge k -> first read in cycle k+1 -> m_valid in cycle k+3.
// Backpressure: reads are throttled so FIFO occupancy plus the in-flight read never exceeds 2.
module result_stream_reader
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_last
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              in_flight_q, in_flight_d;

    logic [1:0]        fifo_count;
    logic [PIX_W-1:0]  fifo_head;
    logic              pop;
    logic              issue;
    logic [2:0]        pending;

    pix_skid_fifo #(
        .W (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_flight_q),
        .pop   (pop),
        .din   (ram_rdata),
        .head  (fifo_head),
        .count (fifo_count)
    );

    // Issue only if the slot freed by this cycle's pop leaves room for the returning read.
    always_comb begin
        m_valid = (fifo_count != 2'd0);
        m_data  = fifo_head;
        m_last  = m_valid && (beat_cnt_q == LAST_BEAT);
        pop     = m_valid && m_ready;
        pending = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, pop};
        issue   = (state_q == STREAM) && (issue_cnt_q < FRAME_CNT) && (pending <= 3'd1);
        busy    = (state_q == STREAM);
        done    = (state_q == DONE);
        ram_raddr = issue ? issue_cnt_q[ADDR_W-1:0] : raddr_q;
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        raddr_d     = raddr_q;
        in_flight_d = issue;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                    raddr_d     = issue_cnt_q[ADDR_W-1:0];
                end
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + CNT_ONE;
                    if (m_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                issue_cnt_d = '0;
                beat_cnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            raddr_q     <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            raddr_q     <= raddr_d;
            in_flight_q <= in_flight_d;
        end
    end

    occupancy_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, fifo_count} + {2'b00, in_flight_q}) <= 3'd2);

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: BRAM model mem[a] = a[7:0], frame scoreboard,
// latency/done timing, backpressure, ignored start, and mid-frame reset.
module tb_result_stream_reader;
    import img_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b1;
    logic              busy, done;
    logic [ADDR_W-1:0] ram_raddr;
    logic [PIX_W-1:0]  ram_rdata = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [PIX_W-1:0]  m_data;
    logic              m_last;

    int err_cnt = 0;
    int chk_cnt = 0;

    result_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // One-cycle-latency BRAM model.
    always @(posedge clk) ram_rdata <= ram_raddr[7:0];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready driver: 0 = low, 1 = high, 2 = random 50%.
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stream monitor / scoreboard.
    bit         mon_en = 1'b0;
    int         beats, data_errs, last_errs, stab_errs, last_seen;
    logic [7:0] first_data;
    logic       pv_valid, pv_ready, pv_last;
    logic [7:0] pv_data;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pv_valid && !pv_ready &&
                    (!m_valid || m_data !== pv_data || m_last !== pv_last))
                    stab_errs++;
                if (m_valid && m_ready) begin
                    if (beats == 0) first_data = m_data;
                    if (m_data !== beats[7:0]) data_errs++;
                    if (m_last !== (beats == FRAME_PIX - 1)) last_errs++;
                    if (m_last) last_seen++;
                    beats++;
                end
            end
            pv_valid = m_valid && mon_en;
            pv_ready = m_ready;
            pv_data  = m_data;
            pv_last  = m_last;
        end
    end

    task automatic reset_mon();
        beats = 0; data_errs = 0; last_errs = 0; stab_errs = 0; last_seen = 0;
        first_data = 8'hxx; pv_valid = 1'b0;
    endtask

    // Leaves the bench at edge k + #1, i.e. in cycle k+1.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int at);
        at = 0;
        for (int j = 1; j <= bound; j++) begin
            @(negedge clk);
            if (done) begin
                at = j;
                break;
            end
        end
    endtask

    task automatic frame_checks(input string tag);
        check_eq({tag, "_beats"}, beats, FRAME_PIX);
        check_eq({tag, "_data_errs"}, data_errs, 0);
        check_eq({tag, "_last_errs"}, last_errs, 0);
        check_eq({tag, "_last_seen"}, last_seen, 1);
        check_eq({tag, "_stab_errs"}, stab_errs, 0);
        check_eq({tag, "_first"}, first_data, 8'h00);
    endtask

    int done_at;

    initial begin
        // Reset held with start asserted: everything stays at zero.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_data", m_data, 0);
        check_eq("rst_raddr", ram_raddr, 0);
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_idle_busy", busy, 0);

        // Full frame, ready high: latency and done timing.
        rdy_mode = 1;
        reset_mon();
        mon_en = 1'b1;
        pulse_start();
        done_at = 0;
        for (int j = 1; j <= 20000; j++) begin
            @(negedge clk);
            if (j == 1) begin
                check_eq("lat_busy_k1", busy, 1);
                check_eq("lat_valid_k1", m_valid, 0);
            end
            if (j == 2) check_eq("lat_valid_k2", m_valid, 0);
            if (j == 3) begin
                check_eq("lat_valid_k3", m_valid, 1);
                check_eq("lat_data_k3", m_data, 8'h00);
            end
            if (done) begin
                done_at = j;
                break;
            end
        end
        check_eq("done_cycle", done_at, 16387);
        check_eq("done_busy", busy, 0);
        @(negedge clk);
        check_eq("done_pulse_len", done, 0);
        frame_checks("f1");

        // Second frame with random backpressure and a stray start mid-stream.
        rdy_mode = 2;
        reset_mon();
        pulse_start();
        repeat (300) @(negedge clk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check_eq("stray_start_busy", busy, 1);
        wait_done(60000, done_at);
        check_eq("rand_done_seen", done_at != 0, 1);
        frame_checks("f2");

        // Ready held low: only addresses 0 and 1 are read, head holds pixel 0.
        rdy_mode = 0;
        reset_mon();
        pulse_start();
        repeat (100) @(negedge clk);
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_data", m_data, 8'h00);
        check_eq("stall_raddr", ram_raddr, 1);
        check_eq("stall_last", m_last, 0);
        check_eq("stall_busy", busy, 1);
        rdy_mode = 1;
        wait_done(20000, done_at);
        check_eq("stall_done_seen", done_at != 0, 1);
        frame_checks("f3");

        // Reset after beat 500 abandons the frame.
        reset_mon();
        pulse_start();
        for (int j = 0; j < 1000 && beats < 500; j++) @(negedge clk);
        check_eq("pre_rst_beats", beats >= 500, 1);
        mon_en = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_valid", m_valid, 0);
        check_eq("mid_rst_last", m_last, 0);
        check_eq("mid_rst_data", m_data, 0);
        check_eq("mid_rst_raddr", ram_raddr, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", busy, 0);
        check_eq("post_rst_valid", m_valid, 0);
        reset_mon();
        mon_en = 1'b1;
        pulse_start();
        wait_done(20000, done_at);
        check_eq("f4_done_at", done_at, 16387);
        frame_checks("f4");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
